// File: rtl/dense_mm_sequencer.sv
// dense_mm_sequencer
//   Drives the dense-dense matrix-multiply engine for one job.
//   For each output row it reads row i of A, then all of B, from two
//   word-pair read memories. The pairs go to the engine through a 2-entry
//   skid FIFO that honours engine backpressure. The result pairs that come
//   back are written to a result memory, and done pulses once all N*N
//   results have been written.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start               begins a job when idle; ignored while a job runs
//   busy, done          job in progress / one-cycle completion pulse
//   a_rd_*, b_rd_*      pair-read ports, data valid one cycle after strobe
//   eng_in_*            valid/ready beat stream to the engine
//                       (lane 1 = even column, lane 2 = odd column)
//   eng_out_*           result pairs from the engine, no backpressure
//   res_we/addr/data    result pair write port, data = {eng_out2, eng_out1}
module dense_mm_sequencer #(
  parameter int N  = 560,
  parameter int DW = 32,
  parameter int RW = 64,
  parameter int AW = $clog2(N*N/2)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            a_rd_en,
  output logic [AW-1:0]   a_rd_addr,
  input  logic [2*DW-1:0] a_rd_data,
  output logic            b_rd_en,
  output logic [AW-1:0]   b_rd_addr,
  input  logic [2*DW-1:0] b_rd_data,
  output logic            eng_in_valid,
  input  logic            eng_in_ready,
  output logic [DW-1:0]   eng_in_data1,
  output logic [DW-1:0]   eng_in_data2,
  output logic            eng_in_is_a,
  input  logic            eng_out_valid,
  input  logic [RW-1:0]   eng_out1,
  input  logic [RW-1:0]   eng_out2,
  output logic            res_we,
  output logic [AW-1:0]   res_addr,
  output logic [2*RW-1:0] res_data
);

  localparam int HALF  = N / 2;
  localparam int PAIRS = N * N / 2;
  localparam int ROW_W = $clog2(N);
  // One extra bit so the result counter can hold the terminal value PAIRS.
  localparam int CNT_W = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic            is_a;
    logic [2*DW-1:0] data;
  } beat_t;

  state_t           r_state;
  state_t           w_next;
  logic [ROW_W-1:0] r_row;
  logic [AW-1:0]    r_col;
  logic [AW-1:0]    r_a_addr;
  logic [AW-1:0]    r_b_addr;
  logic [CNT_W-1:0] r_res_cnt;

  beat_t            r_fifo [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_occ;
  logic             r_outst;
  logic             r_outst_is_a;

  logic             r_res_we;
  logic [AW-1:0]    r_res_addr;
  logic [2*RW-1:0]  r_res_data;

  logic             w_pop;
  logic             w_push;
  logic [1:0]       w_fill;
  logic             w_room;
  logic             w_last_a;
  logic             w_last_b;
  logic             w_last_row;
  logic             w_res_full;
  beat_t            w_head;

  // The FIFO pops when the engine accepts the head beat.
  assign w_pop  = (r_occ != 2'd0) && eng_in_ready;
  // The read issued last cycle returns now and is pushed.
  assign w_push = r_outst;
  // Occupancy left after this cycle's pop, plus the read in flight.
  // A new read is allowed only when that total stays below two, so the
  // returning data always has a FIFO slot waiting for it.
  assign w_fill = r_occ - {1'b0, w_pop} + {1'b0, r_outst};
  assign w_room = (w_fill < 2'd2);

  assign w_last_a   = (r_col == AW'(HALF - 1));
  assign w_last_b   = (r_b_addr == AW'(PAIRS - 1));
  assign w_last_row = (r_row == ROW_W'(N - 1));
  assign w_res_full = (r_res_cnt == CNT_W'(PAIRS));

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples values from before the clock edge.
      r_state <= w_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and read strobes
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would infer a latch.
    w_next  = r_state;
    a_rd_en = 1'b0;
    b_rd_en = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LOAD_A;
      end
      S_LOAD_A: begin
        busy    = 1'b1;
        a_rd_en = w_room;
        if (w_room && w_last_a) w_next = S_LOAD_B;
      end
      S_LOAD_B: begin
        busy    = 1'b1;
        b_rd_en = w_room;
        if (w_room && w_last_b) w_next = w_last_row ? S_DRAIN : S_LOAD_A;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_res_full && (r_occ == 2'd0) && !r_outst) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign a_rd_addr = r_a_addr;
  assign b_rd_addr = r_b_addr;

  // -------------------------------------------------------------------------
  // Address and row counters
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row    <= '0;
      r_col    <= '0;
      r_a_addr <= '0;
      r_b_addr <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      // Start every job from a clean origin, whatever the last job left.
      r_row    <= '0;
      r_col    <= '0;
      r_a_addr <= '0;
      r_b_addr <= '0;
    end else begin
      if (a_rd_en) begin
        // A rows are contiguous, so the A address simply counts up across rows.
        r_a_addr <= r_a_addr + 1'b1;
        r_col    <= w_last_a ? '0 : r_col + 1'b1;
      end
      if (b_rd_en) begin
        r_b_addr <= w_last_b ? '0 : r_b_addr + 1'b1;
        if (w_last_b && !w_last_row) r_row <= r_row + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outstanding read tracking and 2-entry skid FIFO
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outst      <= 1'b0;
      r_outst_is_a <= 1'b0;
      r_wptr       <= 1'b0;
      r_rptr       <= 1'b0;
      r_occ        <= 2'd0;
      // NOTE: the two storage entries are reset as well, because the head
      // entry drives the engine data outputs directly and those must read 0
      // while reset is asserted.
      r_fifo[0]    <= '0;
      r_fifo[1]    <= '0;
    end else begin
      r_outst      <= a_rd_en | b_rd_en;
      r_outst_is_a <= a_rd_en;
      if (w_push) begin
        r_fifo[r_wptr] <= '{is_a: r_outst_is_a,
                            data: r_outst_is_a ? a_rd_data : b_rd_data};
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign w_head       = r_fifo[r_rptr];
  assign eng_in_valid = (r_occ != 2'd0);
  assign eng_in_is_a  = w_head.is_a;
  assign eng_in_data1 = w_head.data[DW-1:0];
  assign eng_in_data2 = w_head.data[2*DW-1:DW];

  // -------------------------------------------------------------------------
  // Result collection
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_cnt  <= '0;
      r_res_we   <= 1'b0;
      r_res_addr <= '0;
      r_res_data <= '0;
    end else begin
      r_res_we <= 1'b0;
      if ((r_state == S_IDLE) && start) begin
        r_res_cnt <= '0;
      end else if (busy && eng_out_valid && !w_res_full) begin
        // Results beyond the last pair, or outside a job, are dropped.
        r_res_we   <= 1'b1;
        r_res_addr <= r_res_cnt[AW-1:0];
        r_res_data <= {eng_out2, eng_out1};
        r_res_cnt  <= r_res_cnt + 1'b1;
      end
    end
  end

  assign res_we   = r_res_we;
  assign res_addr = r_res_addr;
  assign res_data = r_res_data;

endmodule

// File: tb/tb_dense_mm_sequencer.sv
// Self-checking bench for dense_mm_sequencer at N=4.
// Expected read addresses and engine beats are queued when a job is primed.
// Expected result writes are queued when the engine model drives each result.
// The job runner pops and compares these queues as the DUT produces output.
module tb_dense_mm_sequencer;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int RW    = 64;
  localparam int HALF  = N / 2;
  localparam int PAIRS = N * N / 2;
  localparam int AW    = $clog2(PAIRS);
  localparam int BPR   = HALF + PAIRS;   // beats per output row
  localparam int BUDGET = 600;

  typedef struct packed {
    logic          is_a;
    logic [AW-1:0] addr;
  } rd_t;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [2*RW-1:0] data;
  } res_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            busy, done;
  logic            a_rd_en, b_rd_en;
  logic [AW-1:0]   a_rd_addr, b_rd_addr;
  logic [2*DW-1:0] a_rd_data = '0;
  logic [2*DW-1:0] b_rd_data = '0;
  logic            eng_in_valid;
  logic            eng_in_ready = 1'b0;
  logic [DW-1:0]   eng_in_data1, eng_in_data2;
  logic            eng_in_is_a;
  logic            eng_out_valid = 1'b0;
  logic [RW-1:0]   eng_out1 = '0;
  logic [RW-1:0]   eng_out2 = '0;
  logic            res_we;
  logic [AW-1:0]   res_addr;
  logic [2*RW-1:0] res_data;

  int total = 0;
  int bad   = 0;
  bit reset_hit = 0;

  logic [2*DW-1:0] a_mem [PAIRS];
  logic [2*DW-1:0] b_mem [PAIRS];

  rd_t             exp_rd   [$];
  logic [2*DW:0]   exp_beat [$];
  res_t            exp_res  [$];
  int              pend     [$];

  dense_mm_sequencer #(.N(N), .DW(DW), .RW(RW), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .a_rd_en      (a_rd_en),
    .a_rd_addr    (a_rd_addr),
    .a_rd_data    (a_rd_data),
    .b_rd_en      (b_rd_en),
    .b_rd_addr    (b_rd_addr),
    .b_rd_data    (b_rd_data),
    .eng_in_valid (eng_in_valid),
    .eng_in_ready (eng_in_ready),
    .eng_in_data1 (eng_in_data1),
    .eng_in_data2 (eng_in_data2),
    .eng_in_is_a  (eng_in_is_a),
    .eng_out_valid(eng_out_valid),
    .eng_out1     (eng_out1),
    .eng_out2     (eng_out2),
    .res_we       (res_we),
    .res_addr     (res_addr),
    .res_data     (res_data)
  );

  always #5 clk = ~clk;

  // Pair memories with one cycle of read latency.
  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];
    if (b_rd_en) b_rd_data <= b_mem[b_rd_addr];
  end

  task automatic clear_queues();
    exp_rd.delete();
    exp_beat.delete();
    exp_res.delete();
    pend.delete();
  endtask

  // Queue the read addresses and engine beats one whole job should produce.
  task automatic prime_job();
    clear_queues();
    for (int r = 0; r < N; r++) begin
      for (int k = 0; k < HALF; k++) begin
        exp_rd.push_back('{is_a: 1'b1, addr: AW'(r * HALF + k)});
        exp_beat.push_back({1'b1, a_mem[r * HALF + k]});
      end
      for (int k = 0; k < PAIRS; k++) begin
        exp_rd.push_back('{is_a: 1'b0, addr: AW'(k)});
        exp_beat.push_back({1'b0, b_mem[k]});
      end
    end
  endtask

  // Runs one job cycle by cycle.
  // mode 0: ready held high; 1: ready pattern 1,0,0,1; 2: ready low for the
  // first cycles; 3: reset at the 5th B beat of row 1; 4: start pulsed while
  // busy, plus 3 extra result pulses after the last result.
  task automatic run_job(input int mode, output int cycles, output int dones);
    int c = 0;
    int issued = 0;
    int popped = 0;
    int beats = 0;
    int emitted = 0;
    int extra = 0;
    int idx;
    int fill;
    bit seen_done = 0;
    bit stop = 0;
    bit stall_prev = 0;
    bit exp_busy;
    logic [2*DW:0] stall_data = '0;
    logic [2*DW:0] got_beat;
    logic [2*DW:0] eb;
    rd_t  er;
    res_t eres;
    dones  = 0;
    cycles = 0;
    while (!stop) begin
      @(posedge clk);
      #1;
      start = (c == 0) || (mode == 4 && c == 20);
      case (mode)
        1:       eng_in_ready = (c % 4 == 0) || (c % 4 == 3);
        2:       eng_in_ready = (c >= 11);
        default: eng_in_ready = 1'b1;
      endcase
      if (pend.size() > 0) begin
        idx = pend.pop_front();
        eng_out_valid = 1'b1;
        eng_out1 = 64'hE100_0000_0000_0000 | 64'(idx);
        eng_out2 = 64'hE200_0000_0000_0000 | 64'(idx);
        exp_res.push_back('{addr: AW'(idx), data: {eng_out2, eng_out1}});
        emitted++;
        if (mode == 4 && emitted == PAIRS) extra = 3;
      end else if (extra > 0) begin
        eng_out_valid = 1'b1;
        eng_out1 = 64'hDEAD_0000_0000_0001;
        eng_out2 = 64'hDEAD_0000_0000_0002;
        extra--;
      end else begin
        eng_out_valid = 1'b0;
      end

      @(negedge clk);
      got_beat = {eng_in_is_a, eng_in_data2, eng_in_data1};
      total++;
      if (a_rd_en && b_rd_en) begin
        bad++;
        $display("FAIL both_rd c=%0d got a=%b b=%b exp not both", c, a_rd_en, b_rd_en);
      end
      fill = issued - popped - int'(eng_in_valid && eng_in_ready) + int'(a_rd_en || b_rd_en);
      total++;
      if (fill > 2) begin
        bad++;
        $display("FAIL pipe_fill c=%0d got=%0d exp<=2", c, fill);
      end
      if (a_rd_en || b_rd_en) begin
        total++;
        if (exp_rd.size() == 0) begin
          bad++;
          $display("FAIL rd_extra c=%0d got a=%b b=%b exp no read", c, a_rd_en, b_rd_en);
        end else begin
          er = exp_rd.pop_front();
          if (a_rd_en !== er.is_a || (a_rd_en ? a_rd_addr : b_rd_addr) !== er.addr) begin
            bad++;
            $display("FAIL rd_addr c=%0d got is_a=%b addr=%0d exp is_a=%b addr=%0d",
                     c, a_rd_en, a_rd_en ? a_rd_addr : b_rd_addr, er.is_a, er.addr);
          end
        end
        issued++;
      end
      if (stall_prev) begin
        total++;
        if (eng_in_valid !== 1'b1 || got_beat !== stall_data) begin
          bad++;
          $display("FAIL stall_hold c=%0d got v=%b %h exp v=1 %h", c, eng_in_valid, got_beat, stall_data);
        end
      end
      stall_prev = eng_in_valid && !eng_in_ready;
      stall_data = got_beat;
      if (mode == 2 && c == 10) begin
        total++;
        if (issued != 2 || eng_in_valid !== 1'b1 || eng_in_data1 !== a_mem[0][DW-1:0]
            || eng_in_data2 !== a_mem[0][2*DW-1:DW]) begin
          bad++;
          $display("FAIL stall_start got reads=%0d v=%b d1=%h d2=%h exp reads=2 v=1 d1=%h d2=%h",
                   issued, eng_in_valid, eng_in_data1, eng_in_data2,
                   a_mem[0][DW-1:0], a_mem[0][2*DW-1:DW]);
        end
      end
      if (eng_in_valid && eng_in_ready) begin
        total++;
        if (exp_beat.size() == 0) begin
          bad++;
          $display("FAIL beat_extra c=%0d got=%h exp none", c, got_beat);
        end else begin
          eb = exp_beat.pop_front();
          if (got_beat !== eb) begin
            bad++;
            $display("FAIL beat c=%0d got=%h exp=%h", c, got_beat, eb);
          end
        end
        popped++;
        beats++;
        if (beats % BPR == 0)
          for (int j = 0; j < HALF; j++) pend.push_back((beats / BPR - 1) * HALF + j);
        if (mode == 3 && beats == BPR + HALF + 5) begin
          // Reset lands while the 5th B beat of row 1 is being handed over.
          @(posedge clk);
          #1;
          rst = 1'b1;
          start = 1'b0;
          eng_out_valid = 1'b0;
          for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if ({busy, done, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, eng_in_valid,
                 eng_in_data1, eng_in_data2, eng_in_is_a, res_we, res_addr, res_data} !== '0) begin
              bad++;
              $display("FAIL reset_outs got busy=%b done=%b a=%b/%0d b=%b/%0d v=%b d=%h/%h we=%b ra=%0d exp all 0",
                       busy, done, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, eng_in_valid,
                       eng_in_data1, eng_in_data2, res_we, res_addr);
            end
          end
          @(posedge clk);
          #1;
          rst = 1'b0;
          reset_hit = 1'b1;
          stop = 1'b1;
        end
      end
      if (stop) break;
      if (res_we) begin
        total++;
        if (exp_res.size() == 0) begin
          bad++;
          $display("FAIL res_extra c=%0d got addr=%0d data=%h exp no write", c, res_addr, res_data);
        end else begin
          eres = exp_res.pop_front();
          if (res_addr !== eres.addr || res_data !== eres.data) begin
            bad++;
            $display("FAIL res c=%0d got addr=%0d data=%h exp addr=%0d data=%h",
                     c, res_addr, res_data, eres.addr, eres.data);
          end
        end
      end
      exp_busy = (c > 0) && !seen_done && !done;
      total++;
      if (busy !== exp_busy) begin
        bad++;
        $display("FAIL busy c=%0d got=%b exp=%b", c, busy, exp_busy);
      end
      if (done) begin
        dones++;
        cycles = c;
        seen_done = 1'b1;
        total++;
        if (exp_beat.size() != 0 || exp_rd.size() != 0 || exp_res.size() != 0) begin
          bad++;
          $display("FAIL done_early c=%0d got left beats=%0d reads=%0d res=%0d exp 0/0/0",
                   c, exp_beat.size(), exp_rd.size(), exp_res.size());
        end
      end
      c++;
      if (seen_done && pend.size() == 0 && extra == 0) stop = 1'b1;
      if (c >= BUDGET) begin
        total++;
        bad++;
        $display("FAIL timeout got cycles=%0d exp done within %0d", c, BUDGET);
        stop = 1'b1;
      end
    end
    eng_out_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({busy, done, a_rd_en, b_rd_en, eng_in_valid, res_we, a_rd_addr, res_addr} !== '0) begin
      bad++;
      $display("FAIL init_reset got busy=%b done=%b a=%b b=%b v=%b we=%b exp all 0",
               busy, done, a_rd_en, b_rd_en, eng_in_valid, res_we);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_job(input string name, input int dones);
    total++;
    if (dones != 1) begin
      bad++;
      $display("FAIL %s_done got=%0d exp=1", name, dones);
    end
  endtask

  task automatic test_basic();
    int cyc, dn;
    prime_job();
    run_job(0, cyc, dn);
    check_job("basic", dn);
  endtask

  task automatic test_stall_pattern();
    int cyc, dn;
    prime_job();
    run_job(1, cyc, dn);
    check_job("stall_pattern", dn);
  endtask

  task automatic test_stall_start();
    int cyc, dn;
    prime_job();
    run_job(2, cyc, dn);
    check_job("stall_start", dn);
  endtask

  task automatic test_midjob_reset();
    int cyc, dn;
    reset_hit = 1'b0;
    prime_job();
    run_job(3, cyc, dn);
    total++;
    if (reset_hit !== 1'b1 || dn != 0) begin
      bad++;
      $display("FAIL midjob_reset got hit=%b dones=%0d exp hit=1 dones=0", reset_hit, dn);
    end
    prime_job();
    run_job(0, cyc, dn);
    check_job("after_reset", dn);
  endtask

  task automatic test_start_busy_extra();
    int cyc, dn;
    prime_job();
    run_job(4, cyc, dn);
    check_job("start_busy", dn);
  endtask

  task automatic test_back_to_back();
    int cyc1, cyc2, dn1, dn2;
    prime_job();
    run_job(0, cyc1, dn1);
    check_job("b2b_first", dn1);
    prime_job();
    run_job(0, cyc2, dn2);
    check_job("b2b_second", dn2);
    total++;
    if (cyc2 != cyc1) begin
      bad++;
      $display("FAIL b2b_timing got=%0d exp=%0d", cyc2, cyc1);
    end
  endtask

  initial begin
    for (int i = 0; i < PAIRS; i++) begin
      a_mem[i] = {32'hA000_0000 + 32'(2 * i + 1), 32'hA000_0000 + 32'(2 * i)};
      b_mem[i] = {32'hB000_0000 + 32'(2 * i + 1), 32'hB000_0000 + 32'(2 * i)};
    end
    test_reset();
    test_basic();
    test_stall_pattern();
    test_stall_start();
    test_midjob_reset();
    test_start_busy_extra();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dense_mm_sequencer.md
Name: dense_mm_sequencer

Overview:
Controller that sequences the dense-dense matrix-multiply engine. On start it fetches matrix A and matrix B from two word-pair read memories and streams them to the engine. Per output row i it sends row i of A, then all of B, through a 2-entry skid FIFO that honours engine backpressure. It collects the engine's result pairs into a result memory and signals done when all N*N results are written.

Parameters:
N, 560, matrix dimension; must be even, minimum 2
DW, 32, input element width
RW, 64, result element width
AW, $clog2(N*N/2), pair-address width for A, B and result memories

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  pulse; begins a job when the block is idle
busy  out  1  job in progress
done  out  1  one-cycle pulse at job completion
a_rd_en  out  1  A memory read strobe
a_rd_addr  out  AW  A pair address (row*N/2 + col/2)
a_rd_data  in  2*DW  A pair; element col in [DW-1:0], col+1 in [2DW-1:DW]; valid 1 cycle after a_rd_en
b_rd_en  out  1  B memory read strobe
b_rd_addr  out  AW  B pair address
b_rd_data  in  2*DW  B pair; same layout and latency as A
eng_in_valid  out  1  beat valid to engine
eng_in_ready  in  1  engine accepts beat
eng_in_data1  out  DW  lane 1 (even column)
eng_in_data2  out  DW  lane 2 (odd column)
eng_in_is_a  out  1  beat is from A
eng_out_valid  in  1  engine result pair valid; no backpressure
eng_out1  in  RW  result, even column
eng_out2  in  RW  result, odd column
res_we  out  1  result write strobe
res_addr  out  AW  result pair address
res_data  out  2*RW  {eng_out2, eng_out1}

Behaviour:
- Reset (asynchronous, any time, including mid-job) clears the following to 0: all outputs, FSM (goes to IDLE), all counters, FIFO and outstanding-read tracking. Data in flight is discarded.
- FSM states: IDLE, LOAD_A, LOAD_B, DRAIN, DONE.
- IDLE: start=1 -> LOAD_A next cycle, row=0, busy=1. start in any other state is ignored.
- LOAD_A: issues N/2 A reads at row*N/2 + k, k=0..N/2-1. After the last issue -> LOAD_B.
- LOAD_B: issues N*N/2 B reads at address 0..N*N/2-1. After the last issue: if row<N-1, row++ and go to LOAD_A; else go to DRAIN.
- Read issue rule: a read may be issued in cycle t only if fifo_occ(after this cycle's pop) + outstanding < 2. At most one read (A or B) is issued per cycle. a_rd_en and b_rd_en are never both high.
- Read data arrives at t+1 and is pushed into the FIFO tagged with is_a. A push and a pop in the same cycle are both legal.
- FIFO head drives eng_in_*. A pop occurs when eng_in_valid && eng_in_ready. eng_in_* stay stable while valid is high and ready is low.
- With eng_in_ready held at 1, throughput is 1 beat/cycle. The first beat appears 2 cycles after LOAD_A is entered.
- Beat order seen by the engine is exact: for each row i, N/2 A beats then N*N/2 B beats. Total N*(N/2 + N*N/2) beats.
- Result collection, active in LOAD_A, LOAD_B and DRAIN:
  - On each eng_out_valid the block registers res_we=1, res_addr=res_cnt, res_data={eng_out2, eng_out1} one cycle later, then res_cnt++.
  - res_cnt runs 0..N*N/2-1 in row-major pair order.
  - eng_out_valid in IDLE/DONE, or after res_cnt reaches N*N/2, is ignored (no write).
- DRAIN -> DONE when res_cnt == N*N/2 and FIFO and outstanding reads are both empty.
- DONE lasts one cycle: done=1 and busy=0 in that cycle, then -> IDLE.
- busy=1 in LOAD_A, LOAD_B and DRAIN only.
- Address counters wrap cleanly at job end. A new start after done begins again at row 0 with res_cnt=0.

Test Plan:
- N=4, eng_in_ready=1, engine model returns 8 result pairs: 40 beats total in order (2 A beats, 8 B beats) x4; addresses A 0,1 then B 0..7 for row 0; A 2,3 for row 1; res_addr 0..7; done pulses once; busy low in the done cycle.
- N=4 with eng_in_ready toggling 1,0,0,1 repeatedly: beat sequence identical to the unstalled case, no beat dropped or duplicated, eng_in_* stable while stalled, outstanding+occupancy never exceeds 2.
- N=4, eng_in_ready=0 for 10 cycles at start: exactly 2 reads issued, then none until ready=1; eng_in_data1/2 equal A[0][0]/A[0][1].
- Assert rst at the 5th B beat of row 1, release, then start again: all outputs 0 during reset; the new job's first reads are a_rd_addr=0, then 1; res_cnt restarts at 0.
- start pulsed while busy, and 3 extra eng_out_valid pulses after the 8th result: no restart, no res_we beyond address 7, single done.
- Back-to-back jobs with start asserted in the cycle after done: second job output is identical to the first.
